rbit_collector: RTL and testbench
=================================

// Module: rbit_collector
// PURPOSE
//   Consumer end of the cookie machine's serial random-bit stream. Samples one
//   bit per en strobe, packs WIDTH bits into a word and offers it downstream on
//   a valid/ready handshake. Runs a repetition-count health test on the raw bits
//   and keeps sticky fault/overflow flags plus a saturating drop counter.
// PARAMETERS
//   WIDTH    8   bits per output word (>=2)
//   RUN_MAX  32  consecutive identical bits that trip the health fault (>=2)
// PORTS
//   clk         in   1      clock, all state on rising edge
//   rst         in   1      asynchronous reset, active-high
//   en          in   1      bit strobe: rbit valid this cycle
//   rbit        in   1      serial random bit
//   word_o      out  WIDTH  assembled word, first-received bit in MSB
//   valid_o     out  1      word_o holds an unconsumed word
//   ready_i     in   1      downstream accepts word_o when valid_o=1
//   fault_o     out  1      sticky health-test fault
//   overflow_o  out  1      sticky: at least one completed word dropped
//   drop_cnt_o  out  8      dropped-word count, saturates at 255
//   clear_i     in   1      synchronous clear of fault_o/overflow_o/drop_cnt_o
// BEHAVIOUR
//   - Reset (async, rst=1): word_o=0, valid_o=0, fault_o=0, overflow_o=0,
//     drop_cnt_o=0, shift reg=0, bit count=0, run count=0. Outputs clear at once.
//   - en=0: shift reg, bit count, run count unchanged; only handshake acts.
//   - Shift: en=1 -> sreg <= {sreg[WIDTH-2:0], rbit}; bit count 0..WIDTH-1.
//   - Completion: en=1 with bit count=WIDTH-1; word = {sreg[WIDTH-2:0],rbit};
//     bit count wraps to 0. word_o/valid_o update next edge (1-cycle latency).
//   - Output register, states EMPTY (valid_o=0) / FULL (valid_o=1):
//     EMPTY + completion         -> load word, go FULL.
//     FULL + ready_i, no compl.  -> go EMPTY (word_o keeps last value).
//     FULL + ready_i + compl.    -> load new word, stay FULL (no bubble).
//     FULL + !ready_i + compl.   -> new word dropped, word_o unchanged,
//                                   overflow_o<=1, drop_cnt_o+1 (sat. 255).
//     ready_i ignored while EMPTY. word_o stable while FULL and not accepted.
//   - Health test on every en=1: run <= (rbit==last_bit && run!=0) ? run+1 : 1;
//     run saturates at RUN_MAX; last_bit <= rbit. First bit after reset: run=1.
//     fault_o<=1 on the strobe where run becomes RUN_MAX.
//   - Fault does not gate collection; words keep flowing while fault_o=1.
//   - clear_i=1: fault_o, overflow_o, drop_cnt_o -> 0 next edge; run count and
//     data path untouched. Set event in the same cycle wins (flag stays 1;
//     drop_cnt_o becomes 1).
// TESTING
//   1 rst, ready=1, bits 1,0,1,1,0,0,1,0 on consecutive en -> valid_o=1 one cycle
//     after 8th strobe, word_o=8'hB2, valid_o drops next cycle.
//   2 ready=0, feed A5 then 3C -> word_o stays A5, overflow_o=1, drop_cnt_o=1;
//     then ready=1 one cycle -> valid_o=0.
//   3 FULL with 0x11, 0x22 completes same cycle ready=1 -> valid_o stays 1,
//     word_o=0x22, overflow_o=0.
//   4 32 consecutive 1s -> fault_o=1 after 32nd strobe; 31 ones then a 0 ->
//     fault_o=0; clear_i pulse -> fault_o=0.
//   5 same 8 bits as test 1 with random en gaps -> word_o=8'hB2; rst after 5
//     bits mid-word -> outputs 0 at once, next 8 bits form fresh word.
//   6 300 dropped words -> drop_cnt_o=255; clear_i on a drop cycle ->
//     overflow_o=1, drop_cnt_o=1.

Source files
------------

// File: rtl/rbit_collector.sv
// Serial random-bit collector: packs WIDTH strobed bits (first bit in MSB) into a
// word offered on valid/ready, with a repetition-count health test and drop stats.
module rbit_collector #(
    parameter int WIDTH   = 8,
    parameter int RUN_MAX = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rbit,
    output logic [WIDTH-1:0] word_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             fault_o,
    output logic             overflow_o,
    output logic [7:0]       drop_cnt_o,
    input  logic             clear_i,
    output logic             dbg_state
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int RW = $clog2(RUN_MAX + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] RUN_TOP  = RW'(RUN_MAX);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-2:0] sreg_q;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    bit_cnt_q;
    logic [RW-1:0]    run_q, run_d;
    logic             last_q;
    logic             compl;
    logic             load;
    logic             drop;
    logic             fault_set;

    // Handshake: a word transfers on any rising edge where valid_o=1 and
    // ready_i=1; valid_o never drops without a transfer and word_o is held
    // stable until then. A word completing while the held one is not taken
    // is discarded and counted.

    assign shifted = {sreg_q, rbit};
    assign compl   = en && (bit_cnt_q == BIT_LAST);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (compl) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (compl) begin
                    if (ready_i) load = 1'b1;
                    else         drop = 1'b1;
                end else if (ready_i) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // A zero run count marks "no bit seen yet", so the first bit starts a run of 1.
    always_comb begin
        run_d = run_q;
        if (en) begin
            if (rbit == last_q && run_q != '0)
                run_d = (run_q == RUN_TOP) ? run_q : run_q + RW'(1);
            else
                run_d = RW'(1);
        end
    end

    assign fault_set = en && (run_d == RUN_TOP) && (run_q != RUN_TOP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            run_q     <= '0;
            last_q    <= 1'b0;
            word_o    <= '0;
        end else begin
            state_q <= state_d;
            if (en) begin
                sreg_q    <= shifted[WIDTH-2:0];
                bit_cnt_q <= compl ? '0 : bit_cnt_q + CW'(1);
                last_q    <= rbit;
            end
            run_q <= run_d;
            if (load) word_o <= shifted;
        end
    end

    // Status flags: a set event in the same cycle as clear_i takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_o    <= 1'b0;
            overflow_o <= 1'b0;
            drop_cnt_o <= 8'd0;
        end else begin
            if (fault_set)    fault_o <= 1'b1;
            else if (clear_i) fault_o <= 1'b0;

            if (drop)         overflow_o <= 1'b1;
            else if (clear_i) overflow_o <= 1'b0;

            if (clear_i)
                drop_cnt_o <= drop ? 8'd1 : 8'd0;
            else if (drop && drop_cnt_o != 8'hFF)
                drop_cnt_o <= drop_cnt_o + 8'd1;
        end
    end

    assign valid_o   = (state_q == FULL);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rbit_collector.sv
// Bench for rbit_collector: table of known words, directed corner sequences,
// then randomized traffic against a queue-based behavioural model.
module tb_rbit_collector;

    localparam int WIDTH   = 8;
    localparam int RUN_MAX = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             rbit = 1'b0;
    logic             ready_i = 1'b0;
    logic             clear_i = 1'b0;
    logic [WIDTH-1:0] word_o;
    logic             valid_o;
    logic             fault_o;
    logic             overflow_o;
    logic [7:0]       drop_cnt_o;
    logic             dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_q[$];

    typedef struct {
        logic [7:0] bits;
        logic [7:0] exp_word;
    } vec_t;
    vec_t tbl[7];

    rbit_collector #(.WIDTH(WIDTH), .RUN_MAX(RUN_MAX)) dut (
        .clk(clk), .rst(rst), .en(en), .rbit(rbit),
        .word_o(word_o), .valid_o(valid_o), .ready_i(ready_i),
        .fault_o(fault_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o),
        .clear_i(clear_i), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
    task automatic step(input logic e, input logic b, input logic r, input logic c);
        en = e; rbit = b; ready_i = r; clear_i = c;
        @(posedge clk);
        #1;
        en = 1'b0; clear_i = 1'b0;
    endtask

    task automatic feed_word(input logic [7:0] w, input logic r);
        for (int i = WIDTH - 1; i >= 0; i--) step(1'b1, w[i], r, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check({tag, "_rst_word"},  32'(word_o), 32'h0);
        check({tag, "_rst_valid"}, 32'(valid_o), 32'h0);
        check({tag, "_rst_fault"}, 32'(fault_o), 32'h0);
        check({tag, "_rst_ovf"},   32'(overflow_o), 32'h0);
        check({tag, "_rst_drop"},  32'(drop_cnt_o), 32'h0);
    endtask

    function automatic int trailing_run(input bit h[$]);
        int n = 0;
        if (h.size() == 0) return 0;
        for (int i = h.size() - 1; i >= 0; i--) begin
            if (h[i] != h[h.size() - 1]) break;
            n++;
        end
        return n;
    endfunction

    initial begin
        logic [7:0] w;
        bit         m_bits[$];
        bit         m_hist[$];
        logic [7:0] m_word;
        bit         m_valid, m_fault, m_ovf;
        int         m_drop, prev_run;
        bit         e, b, r, c, prev_b, compl, drop;

        tbl[0] = '{8'b10110010, 8'hB2};
        tbl[1] = '{8'b10100101, 8'hA5};
        tbl[2] = '{8'b00111100, 8'h3C};
        tbl[3] = '{8'b00000000, 8'h00};
        tbl[4] = '{8'b11111111, 8'hFF};
        tbl[5] = '{8'b00000001, 8'h01};
        tbl[6] = '{8'b10000000, 8'h80};

        @(posedge clk);
        #1;
        do_reset("init");

        // Table: each word with ready held high, then the idle cycle that accepts it.
        for (int k = 0; k < 7; k++) begin
            feed_word(tbl[k].bits, 1'b1);
            check($sformatf("tbl%0d_valid", k), 32'(valid_o), 32'h1);
            check($sformatf("tbl%0d_word", k), 32'(word_o), 32'(tbl[k].exp_word));
            step(1'b0, 1'b0, 1'b1, 1'b0);
            check($sformatf("tbl%0d_valid_drop", k), 32'(valid_o), 32'h0);
            check($sformatf("tbl%0d_fault", k), 32'(fault_o), 32'h0);
        end

        // Drop while held: A5 stays, 3C is discarded.
        feed_word(8'hA5, 1'b0);
        feed_word(8'h3C, 1'b0);
        check("ovf_word", 32'(word_o), 32'hA5);
        check("ovf_valid", 32'(valid_o), 32'h1);
        check("ovf_flag", 32'(overflow_o), 32'h1);
        check("ovf_cnt", 32'(drop_cnt_o), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("ovf_accept_valid", 32'(valid_o), 32'h0);
        check("ovf_accept_word", 32'(word_o), 32'hA5);

        // Back-to-back: accept 0x11 on the very edge 0x22 completes.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_ovf", 32'(overflow_o), 32'h0);
        check("clr_cnt", 32'(drop_cnt_o), 32'h0);
        feed_word(8'h11, 1'b0);
        w = 8'h22;
        for (int i = WIDTH - 1; i >= 1; i--) step(1'b1, w[i], 1'b0, 1'b0);
        check("b2b_hold_word", 32'(word_o), 32'h11);
        step(1'b1, w[0], 1'b1, 1'b0);
        check("b2b_valid", 32'(valid_o), 32'h1);
        check("b2b_word", 32'(word_o), 32'h22);
        check("b2b_ovf", 32'(overflow_o), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("b2b_done", 32'(valid_o), 32'h0);

        // Health test: 31 ones stay clean, the 32nd trips even with clear_i asserted.
        do_reset("hlth");
        for (int i = 0; i < RUN_MAX - 1; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        check("hlth_31", 32'(fault_o), 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("hlth_32_set_wins", 32'(fault_o), 32'h1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("hlth_sticky", 32'(fault_o), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("hlth_clear", 32'(fault_o), 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < RUN_MAX - 1; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("hlth_31_then_0", 32'(fault_o), 32'h0);

        // Random en gaps, then async reset mid-word.
        do_reset("gap");
        w = 8'hB2;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            step(1'b1, w[i], 1'b0, 1'b0);
        end
        check("gap_word", 32'(word_o), 32'hB2);
        check("gap_valid", 32'(valid_o), 32'h1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("async_word", 32'(word_o), 32'h0);
        check("async_valid", 32'(valid_o), 32'h0);
        #1;
        rst = 1'b0;
        feed_word(8'h5A, 1'b1);
        check("fresh_word", 32'(word_o), 32'h5A);
        check("fresh_valid", 32'(valid_o), 32'h1);

        // Drop counter saturation and clear on a drop cycle.
        do_reset("sat");
        for (int k = 0; k < 301; k++) feed_word(8'(k), 1'b0);
        check("sat_cnt", 32'(drop_cnt_o), 32'd255);
        check("sat_ovf", 32'(overflow_o), 32'h1);
        check("sat_word", 32'(word_o), 32'h00);
        for (int i = 0; i < WIDTH - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("clrdrop_ovf", 32'(overflow_o), 32'h1);
        check("clrdrop_cnt", 32'(drop_cnt_o), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_only_ovf", 32'(overflow_o), 32'h0);
        check("clr_only_cnt", 32'(drop_cnt_o), 32'h0);

        // Randomized traffic against the behavioural model.
        do_reset("rnd");
        exp_q.delete();
        m_word = '0; m_valid = 0; m_fault = 0; m_ovf = 0; m_drop = 0; prev_b = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            e = ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 99) < 97) ? prev_b : ~prev_b;
            r = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 99) == 0);
            if (e) prev_b = b;

            if (m_valid && r) begin
                if (exp_q.size() == 0) check("rnd_sb_empty", 32'h1, 32'h0);
                else check("rnd_sb_word", 32'(word_o), 32'(exp_q.pop_front()));
            end

            compl = 0;
            w = '0;
            if (e) begin
                m_bits.push_back(b);
                if (m_bits.size() == WIDTH) begin
                    foreach (m_bits[i]) w = {w[6:0], m_bits[i]};
                    m_bits.delete();
                    compl = 1;
                end
                prev_run = trailing_run(m_hist);
                m_hist.push_back(b);
                if (m_hist.size() > RUN_MAX) void'(m_hist.pop_front());
                if (trailing_run(m_hist) == RUN_MAX && prev_run != RUN_MAX) m_fault = 1;
                else if (c) m_fault = 0;
            end else if (c) begin
                m_fault = 0;
            end

            drop = compl && m_valid && !r;
            if (compl && !drop) begin
                m_word = w;
                m_valid = 1;
                exp_q.push_back(w);
            end else if (m_valid && r) begin
                m_valid = 0;
            end

            if (drop) m_ovf = 1;
            else if (c) m_ovf = 0;
            if (c) m_drop = drop ? 1 : 0;
            else if (drop && m_drop < 255) m_drop++;

            step(e, b, r, c);
            check("rnd_word", 32'(word_o), 32'(m_word));
            check("rnd_valid", 32'(valid_o), 32'(m_valid));
            check("rnd_fault", 32'(fault_o), 32'(m_fault));
            check("rnd_ovf", 32'(overflow_o), 32'(m_ovf));
            check("rnd_drop", 32'(drop_cnt_o), 32'(m_drop));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
